grass_sprite_drawer: RTL

Downstream consumer of the grass sprite frame RAM: converts the VGA controller's current pixel (DrawX/DrawY) into a tiled read address for the 20x20 grass sprite, waits out the RAM's one-cycle read latency, and maps the returned 3-bit palette index to 24-bit RGB. Feeds the color mapper with a pipeline-aligned is_grass/grass_rgb pair. Index 0 is transparent.

---
 rtl/grass_pkg.sv | 32 +++
 rtl/grass_addr_gen.sv | 57 +++++
 rtl/grass_sprite_drawer.sv | 108 ++++++++++
 3 files changed

// File: rtl/grass_pkg.sv
// Shared constants, types and palette for the grass sprite drawer.
// Pixel geometry and the 8-entry 3-bit-index -> 24-bit RGB palette live here.
package grass_pkg;

    localparam int unsigned SPR_W    = 20;
    localparam int unsigned SPR_H    = 20;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    // Width of the horizontal scroll offset (0..SPR_W-1)
    localparam int unsigned OFF_W    = $clog2(SPR_W);

    typedef logic [23:0] rgb_t;
    typedef logic [2:0]  pal_idx_t;

    // Index 0 is transparent; its RGB value is never driven out as grass
    localparam rgb_t PALETTE [0:7] = '{
        24'h000000,
        24'h3A7D22,
        24'h4F9A2E,
        24'h68B83A,
        24'h2C5E1A,
        24'h8FD14F,
        24'h6B4A2B,
        24'h000000
    };

    function automatic rgb_t pal_lookup(input pal_idx_t idx);
        return PALETTE[idx];
    endfunction

endpackage

// File: rtl/grass_addr_gen.sv
// Pipeline stage 1: classifies the pixel as in/out of the grass strip and
// registers the tiled sprite read address ty*SPR_W + tx.
module grass_addr_gen
    import grass_pkg::*;
#(
    parameter int unsigned GRASS_Y0 = 400,
    parameter int unsigned GRASS_Y1 = 479
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [9:0]       i_draw_x,
    input  logic [9:0]       i_draw_y,
    input  logic [OFF_W-1:0] i_off,
    output logic [18:0]      o_ram_addr,
    output logic             o_s1_valid
);

    logic             w_in_strip;
    logic [10:0]      w_sum_x;
    logic [9:0]       w_dy;
    logic [OFF_W-1:0] w_tx;
    logic [OFF_W-1:0] w_ty;
    logic [8:0]       w_addr;

    logic [18:0]      r_ram_addr;
    logic             r_s1_valid;

    assign w_in_strip = (i_draw_y >= 10'(GRASS_Y0)) &&
                        (i_draw_y <= 10'(GRASS_Y1)) &&
                        (i_draw_x <= 10'(SCREEN_W - 1));

    // 11-bit sum: 639 + 19 cannot overflow
    assign w_sum_x = {1'b0, i_draw_x} + 11'(i_off);

    // Only meaningful in-strip, where DrawY >= GRASS_Y0 so no underflow
    assign w_dy = i_draw_y - 10'(GRASS_Y0);

    // Constant divisors: reduced to constant-mod logic, no runtime divider
    assign w_tx = OFF_W'(w_sum_x % 11'(SPR_W));
    assign w_ty = OFF_W'(w_dy % 10'(SPR_H));

    assign w_addr = 9'(9'(w_ty) * 9'(SPR_W)) + 9'(w_tx);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ram_addr <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_ram_addr <= w_in_strip ? 19'(w_addr) : 19'd0;
            r_s1_valid <= w_in_strip;
        end
    end

    assign o_ram_addr = r_ram_addr;
    assign o_s1_valid = r_s1_valid;

endmodule

// File: rtl/grass_sprite_drawer.sv
// Tiles the 20x20 grass sprite across a screen strip: address -> RAM -> palette, 3-cycle latency.
// Optional macro GRASS_SWAY_EN enables a frame-driven horizontal scroll of the tile pattern.
module grass_sprite_drawer
    import grass_pkg::*;
#(
    parameter int unsigned GRASS_Y0    = 400,
    parameter int unsigned GRASS_Y1    = 479,
    parameter int unsigned SWAY_PERIOD = 8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_start,
    output logic [18:0] ram_addr,
    input  logic [4:0]  ram_data,
    output logic        is_grass,
    output logic [23:0] grass_rgb,
    output logic        px_valid
);

    logic [OFF_W-1:0] w_off;
    logic             w_s1_valid;

    logic             r_s2_valid;
    logic             r_is_grass;
    rgb_t             r_grass_rgb;
    logic             r_px_valid;

    pal_idx_t         w_idx;
    logic             w_is_grass_d;
    rgb_t             w_rgb_d;

`ifdef GRASS_SWAY_EN
    localparam int unsigned CNT_W = (SWAY_PERIOD > 1) ? $clog2(SWAY_PERIOD) : 1;

    logic [CNT_W-1:0] r_frame_cnt;
    logic [OFF_W-1:0] r_off;

    // The pulse that wraps the frame counter also advances the scroll offset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_frame_cnt <= '0;
            r_off       <= '0;
        end else if (frame_start) begin
            if (r_frame_cnt == CNT_W'(SWAY_PERIOD - 1)) begin
                r_frame_cnt <= '0;
                r_off       <= (r_off == OFF_W'(SPR_W - 1)) ? '0 : r_off + 1'b1;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_off = r_off;

    logic w_unused;
    assign w_unused = ^ram_data[4:3];
`else
    assign w_off = '0;

    logic w_unused;
    assign w_unused = ^{frame_start, ram_data[4:3]};
`endif

    grass_addr_gen #(
        .GRASS_Y0 (GRASS_Y0),
        .GRASS_Y1 (GRASS_Y1)
    ) u_addr_gen (
        .i_clk      (Clk),
        .i_rst_n    (Reset_n),
        .i_draw_x   (DrawX),
        .i_draw_y   (DrawY),
        .i_off      (w_off),
        .o_ram_addr (ram_addr),
        .o_s1_valid (w_s1_valid)
    );

    // Stage 2: valid flag tracks the RAM's registered read
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= w_s1_valid;
        end
    end

    assign w_idx        = pal_idx_t'(ram_data[2:0]);
    assign w_is_grass_d = r_s2_valid && (w_idx != 3'd0);
    assign w_rgb_d      = w_is_grass_d ? pal_lookup(w_idx) : 24'h000000;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_is_grass  <= 1'b0;
            r_grass_rgb <= '0;
            r_px_valid  <= 1'b0;
        end else begin
            r_is_grass  <= w_is_grass_d;
            r_grass_rgb <= w_rgb_d;
            r_px_valid  <= r_s2_valid;
        end
    end

    assign is_grass  = r_is_grass;
    assign grass_rgb = r_grass_rgb;
    assign px_valid  = r_px_valid;

endmodule
